// File: rtl/axi4_rd_burst_gen_if.sv
// Signal bundle for axi4_rd_burst_gen: command channel, AR channel,
// R-channel monitor taps and status outputs.
interface axi4_rd_burst_gen_if #(
    parameter int ASIZE   = 32,
    parameter int IDSIZE  = 4,
    parameter int CLSIZE  = 16,
    parameter int MAX_OUT = 8
);
    localparam int OSIZE = $clog2(MAX_OUT + 1);

    // command channel
    logic              cmd_valid;
    logic              cmd_ready;
    logic [ASIZE-1:0]  cmd_addr;
    logic [CLSIZE-1:0] cmd_len;
    logic [IDSIZE-1:0] cmd_id;
    logic              cmd_done;

    // AXI4 AR channel
    logic              axi_arvalid;
    logic              axi_arready;
    logic [ASIZE-1:0]  axi_araddr;
    logic [7:0]        axi_arlen;
    logic [IDSIZE-1:0] axi_arid;
    logic [2:0]        axi_arsize;
    logic [1:0]        axi_arburst;

    // AXI4 R channel (observed only)
    logic              axi_rvalid;
    logic              axi_rready;
    logic              axi_rlast;

    // status
    logic [OSIZE-1:0]  outstanding;
    logic              err_underflow;

    // burst generator side
    modport master (
        input  cmd_valid, cmd_addr, cmd_len, cmd_id,
        output cmd_ready, cmd_done,
        output axi_arvalid, axi_araddr, axi_arlen, axi_arid, axi_arsize, axi_arburst,
        input  axi_arready,
        input  axi_rvalid, axi_rready, axi_rlast,
        output outstanding, err_underflow
    );

    // request source / AXI slave side
    modport slave (
        output cmd_valid, cmd_addr, cmd_len, cmd_id,
        input  cmd_ready, cmd_done,
        input  axi_arvalid, axi_araddr, axi_arlen, axi_arid, axi_arsize, axi_arburst,
        output axi_arready,
        output axi_rvalid, axi_rready, axi_rlast,
        input  outstanding, err_underflow
    );
endinterface

// File: rtl/axi4_rd_burst_gen.sv
// AXI4 read-command burst generator: splits one linear read command into
// INCR bursts of at most MAX_LEN beats that never cross a 4 KB boundary,
// keeps at most MAX_OUT bursts in flight and pulses cmd_done when the last
// burst's final beat has been seen on R.
module axi4_rd_burst_gen #(
    parameter int ASIZE   = 32,
    parameter int DSIZE   = 256,
    parameter int IDSIZE  = 4,
    parameter int MAX_LEN = 16,
    parameter int MAX_OUT = 8,
    parameter int CLSIZE  = 16
) (
    input  logic                axi_aclk,
    input  logic                axi_arst,
    axi4_rd_burst_gen_if.master bus
);

    localparam int BYTES = DSIZE / 8;
    localparam int BSH   = $clog2(BYTES);
    localparam int OW    = $clog2(MAX_OUT + 1);
    localparam int RW    = CLSIZE + 1;
    // wide enough for remaining beats, the 4 KB room (up to 4096) and MAX_LEN
    localparam int BW    = (RW > 13) ? RW : 13;
    localparam logic [ASIZE-1:0] ALIGN_MASK = ~((ASIZE'(1) << BSH) - ASIZE'(1));

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_ISSUE,
        S_WAIT_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ASIZE-1:0]  addr_q, addr_d;
    logic [RW-1:0]     rem_q, rem_d;
    logic [IDSIZE-1:0] id_q, id_d;
    logic              arvalid_q, arvalid_d;
    logic [ASIZE-1:0]  araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic              done_q, done_d;
    logic              ready_q, ready_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic              err_q, err_d;

    logic              cmd_hs;
    logic              ar_hs;
    logic              r_hs;
    logic [BW-1:0]     room;
    logic [BW-1:0]     beats;
    logic [8:0]        issued_beats;

    assign cmd_hs       = bus.cmd_valid & ready_q;
    assign ar_hs        = arvalid_q & bus.axi_arready;
    assign r_hs         = bus.axi_rvalid & bus.axi_rready & bus.axi_rlast;
    assign issued_beats = {1'b0, arlen_q} + 9'd1;

    // Next burst size: min(remaining, MAX_LEN, beats left in this 4 KB page)
    always_comb begin
        room  = BW'((13'd4096 - {1'b0, addr_q[11:0]}) >> BSH);
        beats = BW'(rem_q);
        if (beats > BW'(MAX_LEN)) begin
            beats = BW'(MAX_LEN);
        end
        if (beats > room) begin
            beats = room;
        end
    end

    // Outstanding-burst counter and sticky underflow flag
    always_comb begin
        outst_d = outst_q;
        err_d   = err_q;
        if (ar_hs && !r_hs) begin
            outst_d = outst_q + OW'(1);
        end else if (!ar_hs && r_hs) begin
            if (outst_q == '0) begin
                err_d = 1'b1;
            end else begin
                outst_d = outst_q - OW'(1);
            end
        end else if (ar_hs && r_hs && (outst_q == '0)) begin
            err_d = 1'b1;
        end
    end

    // Command FSM: next state, command bookkeeping and AR field staging
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        id_d     = id_q;
        araddr_d = araddr_q;
        arlen_d  = arlen_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    addr_d  = bus.cmd_addr & ALIGN_MASK;
                    rem_d   = RW'(bus.cmd_len) + RW'(1);
                    id_d    = bus.cmd_id;
                    state_d = S_CALC;
                end
            end

            S_CALC: begin
                araddr_d = addr_q;
                arlen_d  = 8'(beats - BW'(1));
                if (outst_q < OW'(MAX_OUT)) begin
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (ar_hs) begin
                    addr_d  = addr_q + (ASIZE'(issued_beats) << BSH);
                    rem_d   = rem_q - RW'(issued_beats);
                    state_d = (rem_d == '0) ? S_WAIT_DONE : S_CALC;
                end
            end

            S_WAIT_DONE: begin
                // done is raised from the counter's next value so it lands the
                // cycle after the final rlast; the state lingers one cycle so
                // cmd_ready only returns after the pulse
                if (done_q) begin
                    state_d = S_IDLE;
                end else if (outst_d == '0) begin
                    done_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        arvalid_d = (state_d == S_ISSUE);
        ready_d   = (state_d == S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge axi_aclk) begin
        if (axi_arst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            id_q      <= '0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            arlen_q   <= '0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
            outst_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            rem_q     <= rem_d;
            id_q      <= id_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            arlen_q   <= arlen_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
            outst_q   <= outst_d;
            err_q     <= err_d;
        end
    end

    assign bus.cmd_ready     = ready_q;
    assign bus.cmd_done      = done_q;
    assign bus.axi_arvalid   = arvalid_q;
    assign bus.axi_araddr    = araddr_q;
    assign bus.axi_arlen     = arlen_q;
    assign bus.axi_arid      = id_q;
    assign bus.axi_arsize    = 3'(BSH);
    assign bus.axi_arburst   = 2'b01;
    assign bus.outstanding   = outst_q;
    assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_axi4_rd_burst_gen.sv
// Self-checking bench for axi4_rd_burst_gen (DSIZE=256, MAX_LEN=16, MAX_OUT=2).
// A reference model plans each command's bursts arithmetically and tracks
// outstanding bursts, R beats and the expected cmd_done/cmd_ready timing.
module tb_axi4_rd_burst_gen;

    localparam int MAXO = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi4_rd_burst_gen_if #(.ASIZE(32), .IDSIZE(4), .CLSIZE(16), .MAX_OUT(MAXO)) bus ();

    axi4_rd_burst_gen #(
        .ASIZE(32), .DSIZE(256), .IDSIZE(4), .MAX_LEN(16), .MAX_OUT(MAXO), .CLSIZE(16)
    ) dut (
        .axi_aclk(clk),
        .axi_arst(rst),
        .bus     (bus.master)
    );

    typedef struct {
        logic [31:0] a;
        logic [7:0]  l;
    } ar_t;

    ar_t         exp_q[$];
    ar_t         obs_q[$];
    int unsigned rq[$];

    int          n_assert = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned mdl_out  = 0;
    int unsigned cmd_cyc  = 0;
    int unsigned ar_cnt   = 0;
    int unsigned both_cnt = 0;
    bit          busy, done_due, exp_err, prev_stall, prev_ar_hs, prev_both;
    bit          first_ar_pending, rlast_hs, got_done, force_rlast;
    logic [31:0] prev_addr;
    logic [7:0]  prev_len;
    logic [3:0]  prev_id, cur_id;
    int unsigned p_ar = 100, p_rv = 100, p_rr = 100;
    int          ar_mode = 0;  // 0 random arready, 1 accept only with rlast, 2 first AR only

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected burst list from the splitting rules
    function automatic void plan(input logic [31:0] a, input int unsigned len);
        longint unsigned addr;
        int unsigned rem, room, b;
        ar_t e;
        addr = longint'(a) & 64'hFFFF_FFE0;
        rem  = len + 1;
        while (rem > 0) begin
            room = (4096 - int'(addr % 4096)) / 32;
            b = rem;
            if (b > 16)   b = 16;
            if (b > room) b = room;
            e.a = addr[31:0];
            e.l = 8'(b - 1);
            exp_q.push_back(e);
            addr = (addr + longint'(b) * 32) % 64'h1_0000_0000;
            rem -= b;
        end
    endfunction

    // One clock: check current outputs, drive next inputs, update the model
    task automatic step();
        bit rv, rr, rl, ar, arhs, rhs, cmdhs;
        ar_t e;
        chk("outstanding", bus.outstanding, mdl_out);
        chk("cmd_done", bus.cmd_done, done_due);
        chk("cmd_ready", bus.cmd_ready, !busy);
        chk("err_underflow", bus.err_underflow, exp_err);
        chk("arsize", bus.axi_arsize, 3'd5);
        chk("arburst", bus.axi_arburst, 2'b01);
        if (prev_stall) begin
            chk("stall_arvalid", bus.axi_arvalid, 1'b1);
            chk("stall_araddr", bus.axi_araddr, prev_addr);
            chk("stall_arlen", bus.axi_arlen, prev_len);
            chk("stall_arid", bus.axi_arid, prev_id);
        end
        if (prev_ar_hs) chk("ar_bubble", bus.axi_arvalid, 1'b0);
        if (prev_both) chk("ar_rlast_same_cycle", bus.outstanding, mdl_out);
        if (first_ar_pending && bus.axi_arvalid) begin
            chk("first_ar_latency", cyc - cmd_cyc, 2);
            first_ar_pending = 0;
        end
        if (bus.cmd_done) got_done = 1;
        if (done_due) busy = 0;
        done_due = 0;

        rv = (rq.size() > 0) && ($urandom_range(99) < p_rv);
        rr = ($urandom_range(99) < p_rr);
        rl = rv && (rq.size() > 0) && (rq[0] == 1);
        if (force_rlast) begin
            rv = 1; rr = 1; rl = 1;
        end
        case (ar_mode)
            0:       ar = ($urandom_range(99) < p_ar);
            1:       ar = (mdl_out == 0) || (rv && rr && rl);
            default: ar = (ar_cnt == 0);
        endcase
        bus.axi_arready = ar;
        bus.axi_rvalid  = rv;
        bus.axi_rready  = rr;
        bus.axi_rlast   = rl;

        cmdhs    = bus.cmd_valid && bus.cmd_ready;
        arhs     = bus.axi_arvalid && ar;
        rhs      = rv && rr;
        rlast_hs = rhs && rl;

        if (cmdhs) begin
            plan(bus.cmd_addr, int'(bus.cmd_len));
            busy = 1; cmd_cyc = cyc; first_ar_pending = 1;
            cur_id = bus.cmd_id; obs_q.delete(); ar_cnt = 0;
        end
        if (arhs) begin
            chk("ar_expected", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("araddr", bus.axi_araddr, e.a);
                chk("arlen", bus.axi_arlen, e.l);
                chk("arid", bus.axi_arid, cur_id);
            end
            e.a = bus.axi_araddr;
            e.l = bus.axi_arlen;
            obs_q.push_back(e);
            ar_cnt++;
        end
        if (rhs && !force_rlast && rq.size() > 0) begin
            rq[0] = rq[0] - 1;
            if (rl) void'(rq.pop_front());
        end
        if (arhs) rq.push_back(int'(bus.axi_arlen) + 1);
        if (rlast_hs && mdl_out == 0) exp_err = 1;
        if (arhs && !rlast_hs) mdl_out++;
        else if (!arhs && rlast_hs && mdl_out > 0) mdl_out--;
        prev_both = arhs && rlast_hs;
        if (arhs && rlast_hs) both_cnt++;
        if (rlast_hs && !force_rlast && busy && rq.size() == 0 && exp_q.size() == 0 && mdl_out == 0)
            done_due = 1;

        prev_stall = bus.axi_arvalid && !ar;
        prev_ar_hs = arhs;
        prev_addr  = bus.axi_araddr;
        prev_len   = bus.axi_arlen;
        prev_id    = bus.axi_arid;

        @(posedge clk); #1;
        cyc++;
        if (cmdhs) bus.cmd_valid = 0;
    endtask

    task automatic start_cmd(input logic [31:0] a, input logic [15:0] len, input logic [3:0] id);
        bus.cmd_valid = 1; bus.cmd_addr = a; bus.cmd_len = len; bus.cmd_id = id;
        got_done = 0;
    endtask

    task automatic finish_cmd(input string tag);
        for (int i = 0; i < 3000; i++) begin
            if (got_done) break;
            step();
        end
        chk(tag, got_done, 1'b1);
    endtask

    task automatic run_cmd(input logic [31:0] a, input logic [15:0] len, input logic [3:0] id);
        start_cmd(a, len, id);
        finish_cmd("cmd_completes");
    endtask

    task automatic do_reset();
        rst = 1;
        bus.cmd_valid = 0; bus.axi_arready = 0; bus.axi_rvalid = 0;
        bus.axi_rready = 0; bus.axi_rlast = 0;
        @(posedge clk); #1;
        cyc++;
        rst = 0;
        exp_q.delete(); rq.delete(); obs_q.delete();
        mdl_out = 0; busy = 0; done_due = 0; exp_err = 0;
        prev_stall = 0; prev_ar_hs = 0; prev_both = 0; first_ar_pending = 0;
        chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
        chk("rst_arvalid", bus.axi_arvalid, 1'b0);
        chk("rst_araddr", bus.axi_araddr, 32'h0);
        chk("rst_arlen", bus.axi_arlen, 8'h0);
        chk("rst_arid", bus.axi_arid, 4'h0);
        chk("rst_cmd_done", bus.cmd_done, 1'b0);
        chk("rst_outstanding", bus.outstanding, 0);
        chk("rst_err", bus.err_underflow, 1'b0);
    endtask

    initial begin
        logic [31:0] hold_addr;
        logic [7:0]  hold_len;
        int unsigned k;

        rst = 1;
        bus.cmd_valid = 0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_id = '0;
        bus.axi_arready = 0; bus.axi_rvalid = 0; bus.axi_rready = 0; bus.axi_rlast = 0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();

        // 40 beats from 0: three bursts
        run_cmd(32'h0000_0000, 16'd39, 4'h3);
        chk("t1_count", obs_q.size(), 3);
        chk("t1_b0_addr", obs_q[0].a, 32'h000); chk("t1_b0_len", obs_q[0].l, 8'd15);
        chk("t1_b1_addr", obs_q[1].a, 32'h200); chk("t1_b1_len", obs_q[1].l, 8'd15);
        chk("t1_b2_addr", obs_q[2].a, 32'h400); chk("t1_b2_len", obs_q[2].l, 8'd7);

        // 4 KB crossing
        run_cmd(32'h0000_0F80, 16'd7, 4'hA);
        chk("t4k_count", obs_q.size(), 2);
        chk("t4k_b0_addr", obs_q[0].a, 32'h0F80); chk("t4k_b0_len", obs_q[0].l, 8'd3);
        chk("t4k_b1_addr", obs_q[1].a, 32'h1000); chk("t4k_b1_len", obs_q[1].l, 8'd3);

        // address wrap at the top of the space, unaligned low bits dropped
        run_cmd(32'hFFFF_FFF3, 16'd3, 4'h1);
        chk("twrap_count", obs_q.size(), 2);
        chk("twrap_b0_addr", obs_q[0].a, 32'hFFFF_FFE0); chk("twrap_b0_len", obs_q[0].l, 8'd0);
        chk("twrap_b1_addr", obs_q[1].a, 32'h0000_0000); chk("twrap_b1_len", obs_q[1].l, 8'd2);

        // outstanding limit with R held off
        p_rv = 0; p_ar = 100; ar_mode = 0;
        start_cmd(32'h0000_8000, 16'd63, 4'h5);
        repeat (12) step();
        chk("maxout_ar_count", ar_cnt, 2);
        chk("maxout_outstanding", bus.outstanding, 2);
        p_rv = 100; p_rr = 100;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rlast_hs) break;
        end
        k = cyc - 1;
        p_rv = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.axi_arvalid) break;
            step();
        end
        chk("maxout_third_ar_delay", cyc - k, 2);
        p_rv = 70;
        finish_cmd("maxout_completes");

        // arready low for 5 cycles: AR fields hold
        p_ar = 0; p_rv = 100;
        start_cmd(32'h0000_2000, 16'd3, 4'h9);
        for (int i = 0; i < 10; i++) begin
            if (bus.axi_arvalid) break;
            step();
        end
        hold_addr = bus.axi_araddr; hold_len = bus.axi_arlen;
        repeat (5) step();
        chk("hold_arvalid", bus.axi_arvalid, 1'b1);
        chk("hold_araddr", bus.axi_araddr, hold_addr);
        chk("hold_arlen", bus.axi_arlen, hold_len);
        chk("hold_arid", bus.axi_arid, 4'h9);
        p_ar = 100;
        finish_cmd("hold_completes");

        // AR handshake coinciding with rlast
        ar_mode = 1; p_rv = 100; p_rr = 100; both_cnt = 0;
        run_cmd(32'h0000_0000, 16'd31, 4'h3);
        chk("same_cycle_seen", both_cnt > 0, 1'b1);
        ar_mode = 0;

        // spurious rlast at zero outstanding
        step();
        force_rlast = 1;
        step();
        force_rlast = 0;
        step();
        chk("underflow_err", bus.err_underflow, 1'b1);
        chk("underflow_count", bus.outstanding, 0);
        do_reset();

        // reset while a burst is being presented
        ar_mode = 2; p_rv = 0;
        start_cmd(32'h0000_1240, 16'd40, 4'h7);
        for (int i = 0; i < 20; i++) begin
            if (ar_cnt == 1 && bus.axi_arvalid) break;
            step();
        end
        chk("pre_reset_issue", bus.axi_arvalid, 1'b1);
        do_reset();
        ar_mode = 0; p_ar = 100; p_rv = 100;
        run_cmd(32'h0000_3000, 16'd5, 4'h2);
        chk("post_reset_count", obs_q.size(), 1);
        chk("post_reset_addr", obs_q[0].a, 32'h3000);
        chk("post_reset_len", obs_q[0].l, 8'd5);

        // randomized commands
        for (int n = 0; n < 25; n++) begin
            logic [31:0] a;
            p_ar = $urandom_range(30, 100);
            p_rv = $urandom_range(30, 100);
            p_rr = $urandom_range(50, 100);
            a = $urandom;
            if (n % 2 == 0) a[11:0] = 12'(12'hFFF - $urandom_range(0, 600));
            run_cmd(a, 16'($urandom_range(0, 80)), 4'($urandom));
        end
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
